// File: rtl/vga_frame_writer.sv
// vga_frame_writer: queues Avalon register writes and releases committed batches
// only at the start of vertical sync, so display updates never tear mid-frame.
`default_nettype none

module vga_frame_writer #(
  parameter int DEPTH = 16,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [AW-1:0]            cmd_addr,
  input  logic [DW-1:0]            cmd_data,
  input  logic                     cmd_commit,
  input  logic                     vga_vs,
  output logic [AW-1:0]            address,
  output logic [DW-1:0]            writedata,
  output logic                     write,
  output logic                     chipselect,
  input  logic                     waitrequest,
  output logic                     busy,
  output logic                     batch_done,
  output logic                     frame_overrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_next;
  logic [LW-1:0]    level_q, level_d, pending_q, pending_d, batch_len_q, batch_len_d;
  logic [0:0]       state_q, state_d;
  logic             vs_q, write_q, write_d, done_q, done_d, ovr_q, ovr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             push, pop, frame_start;

  assign cmd_ready   = (level_q != LW'(DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign pop         = write_q && !waitrequest;
  assign rd_ptr_next = rd_ptr_q + PW'(1);
  assign frame_start = vs_q && !vga_vs;

  assign level_d   = level_q + LW'(push) - LW'(pop);
  // A commit covers everything present after this cycle's push/pop.
  assign pending_d = cmd_commit ? level_d : (pending_q - LW'(pop));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  always_comb begin
    state_d     = state_q;
    batch_len_d = batch_len_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    ovr_d       = 1'b0;
    if (state_q == S_IDLE) begin
      if (frame_start && (pending_q != '0)) begin
        batch_len_d      = pending_q;
        {addr_d, data_d} = mem_q[rd_ptr_q];
        write_d          = 1'b1;
        state_d          = S_DRAIN;
      end
    end else begin
      ovr_d = frame_start;
      if (pop) begin
        batch_len_d = batch_len_q - LW'(1);
        if (batch_len_q == LW'(1)) begin
          write_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          // Next entry is already committed, so it is safe to present it now.
          {addr_d, data_d} = mem_q[rd_ptr_next];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pending_q   <= '0;
      batch_len_q <= '0;
      state_q     <= S_IDLE;
      vs_q        <= 1'b1;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_next;
      level_q     <= level_d;
      pending_q   <= pending_d;
      batch_len_q <= batch_len_d;
      state_q     <= state_d;
      vs_q        <= vga_vs;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign address       = addr_q;
  assign writedata     = data_q;
  assign write         = write_q;
  assign chipselect    = write_q;
  assign busy          = (state_q == S_DRAIN);
  assign batch_done    = done_q;
  assign frame_overrun = ovr_q;
  assign level         = level_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_writer.sv
// Directed self-checking bench for vga_frame_writer.
`default_nettype none

module tb_vga_frame_writer;

  logic        clk, reset_n, cmd_valid, cmd_ready, cmd_commit, vga_vs;
  logic [5:0]  cmd_addr, address;
  logic [15:0] cmd_data, writedata;
  logic        write, chipselect, waitrequest, busy, batch_done, frame_overrun;
  logic [4:0]  level;

  int n_checks = 0;
  int n_errors = 0;
  int wr_hi = 0, done_cnt = 0, ovr_cnt = 0;
  logic [21:0] got_q[$];
  logic [21:0] exp_q[$];

  vga_frame_writer #(.DEPTH(16), .AW(6), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_commit(cmd_commit), .vga_vs(vga_vs),
    .address(address), .writedata(writedata), .write(write), .chipselect(chipselect),
    .waitrequest(waitrequest), .busy(busy), .batch_done(batch_done),
    .frame_overrun(frame_overrun), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted writes and pulse counts away from the active edge.
  always @(negedge clk) begin
    if (reset_n && write && !waitrequest) got_q.push_back({address, writedata});
    wr_hi    += int'(write);
    done_cnt += int'(batch_done);
    ovr_cnt  += int'(frame_overrun);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] a, input logic [15:0] d, input bit expect_it);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    if (expect_it) exp_q.push_back({a, d});
  endtask

  task automatic commit();
    cmd_commit = 1'b1;
    tick();
    cmd_commit = 1'b0;
  endtask

  task automatic frame();
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, {10'd0, got_q[i]}, {10'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_commit = 1'b0; vga_vs = 1'b1; waitrequest = 1'b0;
    #12;
    check("rst_write", write, 0);
    check("rst_cs", chipselect, 0);
    check("rst_addr", address, 0);
    check("rst_data", writedata, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", batch_done, 0);
    check("rst_ovr", frame_overrun, 0);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // Uncommitted entries must not be released by a frame start.
    push(6'd4, 16'd1, 1); push(6'd5, 16'd100, 1); push(6'd6, 16'd201, 1);
    wr_hi = 0;
    frame();
    repeat (3) tick();
    check("nocommit_wr", wr_hi, 0);
    check("nocommit_level", level, 3);

    // Committed batch: one-cycle latency, back-to-back writes.
    commit();
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    check("b1_w0", {write, chipselect, busy}, 3'b111);
    check("b1_a0", {address, writedata}, {6'd4, 16'd1});
    tick();
    check("b1_a1", {write, address, writedata}, {1'b1, 6'd5, 16'd100});
    tick();
    check("b1_a2", {write, address, writedata}, {1'b1, 6'd6, 16'd201});
    tick();
    check("b1_end", {write, chipselect, batch_done, busy}, 4'b0010);
    check("b1_level", level, 0);
    tick();
    check("b1_donepulse", batch_done, 0);
    check_writes("b1");

    // Wait-state hold on the second write.
    push(6'd7, 16'd11, 1); push(6'd8, 16'd22, 1); push(6'd9, 16'd33, 1);
    commit();
    wr_hi = 0;
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    check("ws_a0", {write, address, writedata}, {1'b1, 6'd7, 16'd11});
    tick();
    waitrequest = 1'b1;
    check("ws_a1", {write, address, writedata}, {1'b1, 6'd8, 16'd22});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_hold", {write, address, writedata}, {1'b1, 6'd8, 16'd22});
    end
    waitrequest = 1'b0;
    tick();
    check("ws_a2", {write, address, writedata}, {1'b1, 6'd9, 16'd33});
    tick();
    check("ws_end", {write, batch_done}, 2'b01);
    repeat (2) tick();
    check("ws_wrhi", wr_hi, 6);
    check_writes("ws");

    // Full FIFO, ignored overflow push, then wrap on a second full batch.
    for (int i = 0; i < 16; i++) push(6'(i), 16'(16'h100 + i), 1);
    check("full_ready", cmd_ready, 0);
    check("full_level", level, 16);
    push(6'd63, 16'hdead, 0);
    check("ovf_level", level, 16);
    commit();
    frame();
    check("full_w0", {write, cmd_ready}, 2'b10);
    tick();
    check("full_ready_back", cmd_ready, 1);
    repeat (20) tick();
    check("full_level0", level, 0);
    check_writes("full1");
    for (int i = 0; i < 16; i++) push(6'(32 + i), 16'(16'h200 + i), 1);
    commit();
    frame();
    repeat (20) tick();
    check_writes("full2");

    // Overrun: commits during drain wait for the next frame.
    for (int i = 0; i < 5; i++) push(6'(20 + i), 16'(500 + i), 1);
    commit();
    ovr_cnt = 0; done_cnt = 0;
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    push(6'd30, 16'd7, 0);
    push(6'd31, 16'd8, 0);
    cmd_commit = 1'b1; vga_vs = 1'b0;
    tick();
    cmd_commit = 1'b0; vga_vs = 1'b1;
    repeat (10) tick();
    check("ovr_cnt", ovr_cnt, 1);
    check("ovr_done", done_cnt, 1);
    check("ovr_level", level, 2);
    check_writes("ovr_b");
    exp_q.push_back({6'd30, 16'd7});
    exp_q.push_back({6'd31, 16'd8});
    frame();
    repeat (5) tick();
    check_writes("ovr_next");
    check("ovr_cnt2", ovr_cnt, 1);

    // Asynchronous reset mid-drain.
    for (int i = 0; i < 5; i++) push(6'(40 + i), 16'(600 + i), 0);
    exp_q.push_back({6'd40, 16'd600});
    exp_q.push_back({6'd41, 16'd601});
    commit();
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    check("ar_write", {write, chipselect, busy}, 3'b000);
    check("ar_level", level, 0);
    #2 reset_n = 1'b1;
    check_writes("ar");
    tick();
    wr_hi = 0;
    frame();
    repeat (5) tick();
    check("ar_nowrite", wr_hi, 0);
    check("ar_level2", level, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
